// File: rtl/four_bit_adder_subtractor.sv
// 4-bit ripple-carry adder/subtractor with combinational flags and a
// registered copy of every result, cleared asynchronously by rst.
module four_bit_adder_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       subtract,
  output logic [3:0] Result,
  output logic       Cout,
  output logic       Overflow,
  output logic       Zero,
  output logic [3:0] Result_q,
  output logic       Cout_q,
  output logic       Overflow_q,
  output logic       Zero_q
);

  logic [3:0] b_inv;
  logic [3:0] sum;
  logic [4:0] carry;

  // subtract inverts B and injects the +1 of the two's complement as carry-in
  assign carry[0] = subtract;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign b_inv[gi]     = B[gi] ^ subtract;
      assign sum[gi]       = A[gi] ^ b_inv[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & b_inv[gi]) | (carry[gi] & (A[gi] ^ b_inv[gi]));
    end
  endgenerate

  assign Result   = sum;
  assign Cout     = carry[4];
  assign Overflow = carry[3] ^ carry[4];
  assign Zero     = ~|sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result_q   <= 4'b0000;
      Cout_q     <= 1'b0;
      Overflow_q <= 1'b0;
      Zero_q     <= 1'b0;
    end else begin
      Result_q   <= Result;
      Cout_q     <= Cout;
      Overflow_q <= Overflow;
      Zero_q     <= Zero;
    end
  end

endmodule

// File: tb/tb_four_bit_adder_subtractor.sv
// Self-checking bench: directed vectors, exhaustive sweep and random
// back-to-back traffic against an integer-arithmetic reference model.
module tb_four_bit_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       subtract = 1'b0;
  logic [3:0] result;
  logic       cout;
  logic       overflow;
  logic       zero;
  logic [3:0] result_q;
  logic       cout_q;
  logic       overflow_q;
  logic       zero_q;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  four_bit_adder_subtractor dut (
    .clk        (clk),
    .rst        (rst),
    .A          (a),
    .B          (b),
    .subtract   (subtract),
    .Result     (result),
    .Cout       (cout),
    .Overflow   (overflow),
    .Zero       (zero),
    .Result_q   (result_q),
    .Cout_q     (cout_q),
    .Overflow_q (overflow_q),
    .Zero_q     (zero_q)
  );

  // Reference: plain unsigned/signed integer arithmetic
  function automatic void model(input logic [3:0] ma, input logic [3:0] mb, input logic msub,
                                output logic [3:0] r, output logic c, output logic o,
                                output logic z);
    int ua, ub, sa, sb, u, s;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    u  = msub ? ua - ub : ua + ub;
    s  = msub ? sa - sb : sa + sb;
    r  = 4'(((u % 16) + 16) % 16);
    c  = msub ? (ua >= ub) : (u > 15);
    o  = (s > 7) || (s < -8);
    z  = (r == 4'd0);
  endfunction

  // {A, B, subtract, Result, Cout, Overflow, Zero}
  localparam logic [15:0] VECS [14] = '{
    {4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1},
    {4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0},
    {4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0},
    {4'h4, 4'h5, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0},
    {4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0},
    {4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1},
    {4'h1, 4'h1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1},
    {4'h2, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0},
    {4'h4, 4'h5, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0},
    {4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1},
    {4'hF, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0},
    {4'h0, 4'hF, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0},
    {4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0},
    {4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0}
  };

  task automatic test_reset();
    a = 4'd0; b = 4'd0; subtract = 1'b0;
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({result_q, cout_q, overflow_q, zero_q} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_async: q=%b expected 0000000", {result_q, cout_q, overflow_q, zero_q});
    end
    repeat (3) @(posedge clk);
    #1;
    // Zero is 1 combinationally, but Zero_q must stay 0 while in reset
    tests_run++;
    if ({result_q, cout_q, overflow_q, zero_q} !== 7'b0 || zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hold: q=%b zero=%b expected q=0000000 zero=1",
               {result_q, cout_q, overflow_q, zero_q}, zero);
    end
    $display("[TB] reset: q=%b", {result_q, cout_q, overflow_q, zero_q});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [15:0] v;
    for (int i = 0; i < 14; i++) begin
      v = VECS[i];
      a = v[15:12]; b = v[11:8]; subtract = v[7];
      #1;
      tests_run++;
      if ({result, cout, overflow, zero} !== v[6:0]) begin
        tests_failed++;
        $display("FAIL vector%0d: A=%h B=%h sub=%b got r/c/o/z=%b expected %b",
                 i, a, b, subtract, {result, cout, overflow, zero}, v[6:0]);
      end
      $display("[TB] vector%0d: %h %s %h -> %b c=%b o=%b z=%b", i, a, subtract ? "-" : "+",
               b, result, cout, overflow, zero);
    end
  endtask

  task automatic test_registered_and_midop_reset();
    logic [3:0] er;
    logic ec, eo, ez;
    @(negedge clk);
    a = 4'd2; b = 4'd3; subtract = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, cout_q, overflow_q, zero_q} !== {4'b0101, 3'b000}) begin
      tests_failed++;
      $display("FAIL reg_capture: q=%b expected 0101000", {result_q, cout_q, overflow_q, zero_q});
    end
    a = 4'd9; b = 4'd9;
    #2;
    tests_run++;
    if (result_q !== 4'b0101) begin
      tests_failed++;
      $display("FAIL reg_hold: Result_q=%b expected 0101", result_q);
    end
    $display("[TB] registered: Result_q=%b after input change", result_q);
    rst = 1'b1;
    #1;
    model(a, b, subtract, er, ec, eo, ez);
    tests_run++;
    if ({result_q, cout_q, overflow_q, zero_q} !== 7'b0 ||
        {result, cout, overflow, zero} !== {er, ec, eo, ez}) begin
      tests_failed++;
      $display("FAIL midop_reset: q=%b comb=%b expected q=0000000 comb=%b",
               {result_q, cout_q, overflow_q, zero_q}, {result, cout, overflow, zero},
               {er, ec, eo, ez});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, cout_q, overflow_q, zero_q} !== {er, ec, eo, ez}) begin
      tests_failed++;
      $display("FAIL reset_release: q=%b expected %b", {result_q, cout_q, overflow_q, zero_q},
               {er, ec, eo, ez});
    end
    $display("[TB] midop reset/release: q=%b", {result_q, cout_q, overflow_q, zero_q});
  endtask

  task automatic test_exhaustive();
    logic [3:0] er;
    logic ec, eo, ez;
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      a = 4'(i >> 5); b = 4'(i >> 1); subtract = i[0];
      #1;
      model(a, b, subtract, er, ec, eo, ez);
      tests_run++;
      if ({result, cout, overflow, zero} !== {er, ec, eo, ez}) begin
        tests_failed++;
        bad++;
        $display("FAIL sweep: A=%h B=%h sub=%b got %b expected %b", a, b, subtract,
                 {result, cout, overflow, zero}, {er, ec, eo, ez});
      end
    end
    $display("[TB] exhaustive sweep: 512 combinations, %0d wrong", bad);
  endtask

  task automatic test_back_to_back();
    logic [3:0] er;
    logic ec, eo, ez;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      subtract = 1'($urandom_range(0, 1));
      model(a, b, subtract, er, ec, eo, ez);
      @(posedge clk);
      #1;
      tests_run++;
      if ({result_q, cout_q, overflow_q, zero_q} !== {er, ec, eo, ez}) begin
        tests_failed++;
        $display("FAIL back_to_back%0d: A=%h B=%h sub=%b got q=%b expected %b", i, a, b,
                 subtract, {result_q, cout_q, overflow_q, zero_q}, {er, ec, eo, ez});
      end
      $display("[TB] b2b%0d: %h %s %h -> q=%b", i, a, subtract ? "-" : "+", b,
               {result_q, cout_q, overflow_q, zero_q});
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_registered_and_midop_reset();
    test_exhaustive();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
